// File: rtl/sram_controller.sv
// Two-phase 16-bit SRAM sequencer for 32-bit MEM-stage loads/stores.
// Holds `ready` low while a word access is split into LO/HI half-word phases.
module sram_controller #(
  parameter int          ADDR_WIDTH  = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [31:0]           ALU_Res,
  input  logic [31:0]           ST_val,
  output logic [31:0]           read_data,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [15:0]           SRAM_DQ_out,
  input  logic [15:0]           SRAM_DQ_in,
  output logic                  SRAM_DQ_oe,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [29:0]   word;
  logic [31:0]   wdata;
  logic          rw;
  logic          req;
  logic          last;
  logic [31:0]   offset;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign last   = (cnt == CW'(WAIT_CYCLES - 1));
  assign offset = ALU_Res - BASE_ADDR;
  assign ready  = ((state == IDLE) && !req) || (state == DONE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      word      <= '0;
      wdata     <= '0;
      rw        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          word  <= 30'(offset >> 2);
          wdata <= ST_val;
          // simultaneous R/W enables resolve to a read
          rw    <= MEM_W_EN & ~MEM_R_EN;
          cnt   <= '0;
          state <= LO;
        end
        LO, HI: begin
          if (last) begin
            cnt <= '0;
            if (!rw) begin
              if (state == LO) read_data[15:0]  <= SRAM_DQ_in;
              else             read_data[31:16] <= SRAM_DQ_in;
            end
            state <= (state == LO) ? HI : DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin decode uses only registered state so strobes are clean for a whole cycle.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    if (state == LO || state == HI) begin
      SRAM_ADDR = ADDR_WIDTH'({word, state == HI});
      if (rw) begin
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = (state == HI) ? wdata[31:16] : wdata[15:0];
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES=2 and 1)
// against a behavioural SRAM that commits a write after a full-length WE_N pulse.
module tb_sram_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = '0, ST_val = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;

  logic        r_en1 = 1'b0, w_en1 = 1'b0;
  logic [31:0] alu1 = '0, st1 = '0;
  logic [31:0] read_data1;
  logic        ready1;
  logic [17:0] addr1;
  logic [15:0] dq_out1, dq_in1;
  logic        dq_oe1, we_n1, oe_n1;

  int ntests = 0, nfail = 0;
  int we_tot = 0, oe_tot = 0;
  int n, base_we, base_oe;

  logic [15:0] mem [256] = '{0: 16'hBEEF, 1: 16'hCAFE, 2: 16'h3333, 3: 16'h4444,
                             9: 16'h1111, default: 16'h0000};
  logic [17:0] wa = '0;
  int          wrun = 0;

  always #5 CLK = ~CLK;

  sram_controller #(.ADDR_WIDTH(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut (
    .CLK(CLK), .RST(RST), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .ST_val(ST_val), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N));

  sram_controller #(.ADDR_WIDTH(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
    .CLK(CLK), .RST(RST), .MEM_R_EN(r_en1), .MEM_W_EN(w_en1),
    .ALU_Res(alu1), .ST_val(st1), .read_data(read_data1), .ready(ready1),
    .SRAM_ADDR(addr1), .SRAM_DQ_out(dq_out1), .SRAM_DQ_in(dq_in1),
    .SRAM_DQ_oe(dq_oe1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1));

  assign SRAM_DQ_in = !SRAM_OE_N ? mem[SRAM_ADDR[7:0]] : 16'h0000;
  assign dq_in1     = {8'h5A, addr1[7:0]};

  // Write commits only once WE_N has been held WAIT_CYCLES cycles on one address.
  always @(posedge CLK) begin
    if (!SRAM_WE_N) begin
      if (SRAM_ADDR != wa) wrun = 0;
      wa   = SRAM_ADDR;
      wrun = wrun + 1;
      if (wrun == 2) mem[wa[7:0]] = SRAM_DQ_out;
    end else begin
      wrun = 0;
    end
  end

  always @(negedge CLK) begin
    if (!SRAM_WE_N) we_tot = we_tot + 1;
    if (!SRAM_OE_N) oe_tot = oe_tot + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic start(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    MEM_R_EN = r; MEM_W_EN = w; ALU_Res = a; ST_val = d;
  endtask

  task automatic idle;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  // Counts cycles with ready low from the current cycle; returns at the DONE negedge.
  task automatic wait_done(input bit which, output int cnt);
    bit fin = 1'b0;
    cnt = 0;
    while (!fin) begin
      @(negedge CLK);
      if (which ? ready1 : ready) fin = 1'b1;
      else begin
        cnt++;
        if (cnt > 40) begin
          check("timeout", 32'd0, 32'd1);
          fin = 1'b1;
        end else step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) step();
    @(negedge CLK);
    check("rst_ready", ready, 1);
    check("rst_rdata", read_data, 0);
    check("rst_pins", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 3'b110);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_dqout", SRAM_DQ_out, 0);
    check("rst_ready1", ready1, 1);
    step(); RST = 1'b1; step();

    // store 0x12345678 to 1032 -> half-words 4,5
    base_we = we_tot;
    start(0, 1, 32'd1032, 32'h1234_5678);
    wait_done(0, n);
    check("st_stall", n, 5);
    step(); idle();
    check("st_lo", mem[4], 16'h5678);
    check("st_hi", mem[5], 16'h1234);
    check("st_we_cycles", we_tot - base_we, 4);

    // load back
    base_oe = oe_tot; base_we = we_tot;
    start(1, 0, 32'd1032, 32'h0);
    wait_done(0, n);
    check("ld_data", read_data, 32'h1234_5678);
    check("ld_stall", n, 5);
    step(); idle();
    check("ld_oe_cycles", oe_tot - base_oe, 4);
    check("ld_we_cycles", we_tot - base_we, 0);

    // no request for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge CLK);
      check("idle_pins", {ready, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe, SRAM_ADDR == 18'd0}, 5'b11101);
    end

    // both enables high -> read
    step();
    base_we = we_tot; base_oe = oe_tot;
    start(1, 1, 32'd1024, 32'hDEAD_0000);
    wait_done(0, n);
    check("both_data", read_data, 32'hCAFE_BEEF);
    step(); idle();
    check("both_we", we_tot - base_we, 0);
    check("both_oe", oe_tot - base_oe, 4);
    check("both_mem", {mem[1], mem[0]}, 32'hCAFE_BEEF);

    // reset during the HI write phase of a store to 1040 (half-words 8,9)
    start(0, 1, 32'd1040, 32'hAABB_CCDD);
    @(negedge CLK);
    step(); step(); step();
    @(negedge CLK);
    check("rst_mid_hi_we", {SRAM_WE_N, 14'h0, SRAM_ADDR}, {1'b0, 14'h0, 18'd9});
    RST = 1'b0; idle();
    step();
    @(negedge CLK);
    check("rst_mid_ready", ready, 1);
    check("rst_mid_we", SRAM_WE_N, 1);
    check("rst_mid_rdata", read_data, 0);
    RST = 1'b1;
    step();
    check("rst_mid_lo", mem[8], 16'hCCDD);
    check("rst_mid_hi", mem[9], 16'h1111);

    // inputs change during LO: latched address/data must be used
    start(0, 1, 32'd1048, 32'h0BAD_F00D);
    @(negedge CLK);
    step();
    ALU_Res = 32'd2000; ST_val = 32'hFFFF_FFFF;
    wait_done(0, n);
    check("chg_stall", n, 4);
    step(); idle();
    check("chg_lo", mem[12], 16'hF00D);
    check("chg_hi", mem[13], 16'h0BAD);

    // WAIT_CYCLES=1 instance
    r_en1 = 1'b1; alu1 = 32'd1024;
    wait_done(1, n);
    check("w1_stall", n, 3);
    check("w1_data", read_data1, 32'h5A01_5A00);
    step(); r_en1 = 1'b0;

    // back-to-back loads 1024 then 1028
    start(1, 0, 32'd1024, 32'h0);
    wait_done(0, n);
    check("b2b_first", read_data, 32'hCAFE_BEEF);
    step();
    ALU_Res = 32'd1028;
    wait_done(0, n);
    check("b2b_stall", n, 5);
    check("b2b_second", read_data, 32'h4444_3333);
    step(); idle();

    // address wrap: 1024 + 2^19 maps to half-words 0 and 1
    start(1, 0, 32'd1024 + 32'h0008_0000, 32'h0);
    @(negedge CLK);
    step();
    @(negedge CLK);
    check("wrap_lo", {SRAM_OE_N, 13'h0, SRAM_ADDR}, {1'b0, 13'h0, 18'd0});
    step(); step();
    @(negedge CLK);
    check("wrap_hi", SRAM_ADDR, 1);
    step();
    wait_done(0, n);
    check("wrap_data", read_data, 32'hCAFE_BEEF);
    step(); idle();
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
